// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller and its per-source FSMs.
package irq_ctrl_pkg;

   localparam int          NUM_SRC  = 3;
   localparam logic [1:0]  IRQ_NONE = 2'b11;
   localparam logic [7:0]  LOST_MAX = 8'hFF;

   // Bit 0 = pending, bit 1 = in service, so the outputs decode straight from the state.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_PEND      = 2'b01,
      ST_SERV      = 2'b10,
      ST_SERV_PEND = 2'b11
   } src_state_e;

   function automatic logic [7:0] lost_add(input logic [7:0] cnt, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, cnt} + {7'b0, inc};
      return sum[8] ? LOST_MAX : sum[7:0];
   endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CP0-facing signal bundle of the interrupt controller.
interface irq_ctrl_if;
   import irq_ctrl_pkg::*;

   logic [NUM_SRC-1:0] irq_in;
   logic [NUM_SRC-1:0] block;
   logic               has_exp;
   logic               is_eret;
   logic               eret_valid;
   logic [NUM_SRC-1:0] exp_src;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] in_service;
   logic [1:0]         irq_id;
   logic [7:0]         lost_cnt;

   modport slave (
      input  irq_in, block, has_exp, is_eret, eret_valid,
      output exp_src, pending, in_service, irq_id, lost_cnt
   );

   modport master (
      output irq_in, block, has_exp, is_eret, eret_valid,
      input  exp_src, pending, in_service, irq_id, lost_cnt
   );

endinterface

// File: rtl/irq_ctrl_irq_src_fsm.sv
// One interrupt source: 2-flop synchronizer, armed rising-edge detect, service-state FSM.
//
// state        | meaning
// ST_IDLE      | nothing outstanding
// ST_PEND      | request waiting for acknowledge
// ST_SERV      | handler running, no new request
// ST_SERV_PEND | handler running, another request queued
module irq_src_fsm
   import irq_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic irq_raw,
   input  logic ack,
   input  logic ret,
   output logic pending,
   output logic in_service,
   output logic lost
);

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       prev_q,  prev_d;
   logic       vld1_q,  vld1_d;
   logic       vld2_q,  vld2_d;
   logic       armed_q, armed_d;
   logic       rise;
   src_state_e state_q, state_d;

   // Edges are only honoured once the synchronized line has been seen low,
   // so a line already high at reset release never looks like a new request.
   always_comb begin
      sync1_d = irq_raw;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      vld1_d  = 1'b1;
      vld2_d  = vld1_q;
      armed_d = armed_q | (vld2_q & ~sync2_q);
      rise    = armed_q & sync2_q & ~prev_q;
      state_d = state_q;
      lost    = 1'b0;
      case (state_q)
         ST_IDLE:      if (rise) state_d = ST_PEND;
         ST_PEND: begin
            if (ack)       state_d = rise ? ST_SERV_PEND : ST_SERV;
            else if (rise) lost    = 1'b1;
         end
         ST_SERV: begin
            if (ret)       state_d = rise ? ST_PEND : ST_IDLE;
            else if (rise) state_d = ST_SERV_PEND;
         end
         ST_SERV_PEND: begin
            if (ret) state_d = ST_PEND;
            lost = rise;
         end
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         vld1_q  <= 1'b0;
         vld2_q  <= 1'b0;
         armed_q <= 1'b0;
         state_q <= ST_IDLE;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         vld1_q  <= vld1_d;
         vld2_q  <= vld2_d;
         armed_q <= armed_d;
         state_q <= state_d;
      end
   end

   assign pending    = state_q[0];
   assign in_service = state_q[1];

endmodule

// File: rtl/irq_ctrl.sv
// Three-source nested interrupt controller: priority selection, ack/eret routing, lost-edge counter.
module irq_ctrl
   import irq_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   irq_ctrl_if.slave  bus
);

   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] serv;
   logic [NUM_SRC-1:0] lost;
   logic [NUM_SRC-1:0] elig;
   logic [NUM_SRC-1:0] sel;
   logic [NUM_SRC-1:0] ack;
   logic [NUM_SRC-1:0] ret_sel;
   logic [NUM_SRC-1:0] ret;
   logic [1:0]         sel_id;
   logic [1:0]         lost_inc;
   logic [7:0]         lost_cnt_q, lost_cnt_d;
   logic               masked_by_serv;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      irq_src_fsm u_src (
         .clk        (clk),
         .reset      (reset),
         .irq_raw    (bus.irq_in[g]),
         .ack        (ack[g]),
         .ret        (ret[g]),
         .pending    (pend[g]),
         .in_service (serv[g]),
         .lost       (lost[g])
      );
   end

   // A source is eligible only if nothing of equal or higher priority is in service.
   always_comb begin
      elig    = '0;
      sel     = '0;
      sel_id  = IRQ_NONE;
      ret_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         masked_by_serv = 1'b0;
         for (int j = i; j < NUM_SRC; j++) masked_by_serv = masked_by_serv | serv[j];
         elig[i] = pend[i] & ~bus.block[i] & ~masked_by_serv;
      end
      masked_by_serv = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (elig[i]) begin
            sel    = '0;
            sel[i] = 1'b1;
            sel_id = 2'(i);
         end
         if (serv[i]) begin
            ret_sel    = '0;
            ret_sel[i] = 1'b1;
         end
      end
   end

   assign ack = bus.has_exp ? sel : '0;
   assign ret = (bus.is_eret & bus.eret_valid) ? ret_sel : '0;

   always_comb begin
      lost_inc   = {1'b0, lost[0]} + {1'b0, lost[1]} + {1'b0, lost[2]};
      lost_cnt_d = lost_add(lost_cnt_q, lost_inc);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) lost_cnt_q <= 8'h00;
      else        lost_cnt_q <= lost_cnt_d;
   end

   assign bus.exp_src    = sel;
   assign bus.irq_id     = sel_id;
   assign bus.pending    = pend;
   assign bus.in_service = serv;
   assign bus.lost_cnt   = lost_cnt_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: vector table plus hand-written corner sequences.
module tb_irq_ctrl;
   import irq_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   irq_ctrl_if bus();

   irq_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] irq;
      logic [2:0] blk;
      logic       hexp;
      logic       eret;
      logic       ev;
      int         ncyc;
      logic [2:0] p;
      logic [2:0] s;
      logic [2:0] x;
      logic [1:0] id;
      logic [7:0] lost;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(input logic [2:0] irq, input logic [2:0] blk, input logic hexp,
                               input logic eret, input logic ev, input int ncyc,
                               input logic [2:0] p, input logic [2:0] s, input logic [2:0] x,
                               input logic [1:0] id, input logic [7:0] lost);
      vec_t v;
      v.irq = irq; v.blk = blk; v.hexp = hexp; v.eret = eret; v.ev = ev; v.ncyc = ncyc;
      v.p = p; v.s = s; v.x = x; v.id = id; v.lost = lost;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] p, input logic [2:0] s,
                          input logic [2:0] x, input logic [1:0] id, input logic [7:0] lost);
      chk({tag, ".pending"},    8'(bus.pending),    8'(p));
      chk({tag, ".in_service"}, 8'(bus.in_service), 8'(s));
      chk({tag, ".exp_src"},    8'(bus.exp_src),    8'(x));
      chk({tag, ".irq_id"},     8'(bus.irq_id),     8'(id));
      chk({tag, ".lost_cnt"},   bus.lost_cnt,       lost);
   endtask

   task automatic drive(input logic [2:0] irq, input logic [2:0] blk, input logic hexp,
                        input logic eret, input logic ev);
      bus.irq_in     = irq;
      bus.block      = blk;
      bus.has_exp    = hexp;
      bus.is_eret    = eret;
      bus.eret_valid = ev;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      //              irq     blk   hx eret ev n   pend    serv    exp     id     lost
      vecs[0]  = mk(3'b001, 3'b000, 0, 0, 0, 2, 3'b000, 3'b000, 3'b000, 2'd3, 8'd0);
      vecs[1]  = mk(3'b000, 3'b000, 0, 0, 0, 1, 3'b001, 3'b000, 3'b001, 2'd0, 8'd0);
      vecs[2]  = mk(3'b000, 3'b000, 0, 0, 0, 3, 3'b001, 3'b000, 3'b001, 2'd0, 8'd0);
      vecs[3]  = mk(3'b000, 3'b000, 1, 0, 0, 1, 3'b000, 3'b001, 3'b000, 2'd3, 8'd0);
      vecs[4]  = mk(3'b100, 3'b000, 0, 0, 0, 3, 3'b100, 3'b001, 3'b100, 2'd2, 8'd0);
      vecs[5]  = mk(3'b000, 3'b000, 1, 0, 0, 1, 3'b000, 3'b101, 3'b000, 2'd3, 8'd0);
      vecs[6]  = mk(3'b010, 3'b000, 0, 0, 0, 3, 3'b010, 3'b101, 3'b000, 2'd3, 8'd0);
      vecs[7]  = mk(3'b000, 3'b000, 0, 0, 0, 3, 3'b010, 3'b101, 3'b000, 2'd3, 8'd0);
      vecs[8]  = mk(3'b100, 3'b000, 0, 0, 0, 3, 3'b110, 3'b101, 3'b000, 2'd3, 8'd0);
      vecs[9]  = mk(3'b000, 3'b000, 0, 1, 1, 1, 3'b110, 3'b001, 3'b100, 2'd2, 8'd0);
      vecs[10] = mk(3'b000, 3'b000, 0, 1, 0, 1, 3'b110, 3'b001, 3'b100, 2'd2, 8'd0);
      vecs[11] = mk(3'b000, 3'b100, 0, 0, 0, 1, 3'b110, 3'b001, 3'b010, 2'd1, 8'd0);
      vecs[12] = mk(3'b000, 3'b000, 1, 0, 0, 1, 3'b010, 3'b101, 3'b000, 2'd3, 8'd0);
      vecs[13] = mk(3'b000, 3'b000, 0, 1, 1, 1, 3'b010, 3'b001, 3'b010, 2'd1, 8'd0);
      vecs[14] = mk(3'b000, 3'b000, 0, 1, 1, 1, 3'b010, 3'b000, 3'b010, 2'd1, 8'd0);
      vecs[15] = mk(3'b010, 3'b000, 0, 0, 0, 3, 3'b010, 3'b000, 3'b010, 2'd1, 8'd1);
      vecs[16] = mk(3'b000, 3'b000, 0, 0, 0, 3, 3'b010, 3'b000, 3'b010, 2'd1, 8'd1);
      vecs[17] = mk(3'b010, 3'b000, 0, 0, 0, 3, 3'b010, 3'b000, 3'b010, 2'd1, 8'd2);

      drive(3'b000, 3'b000, 0, 0, 0);
      step(3);
      chk_all("reset", 3'b000, 3'b000, 3'b000, 2'd3, 8'd0);
      @(negedge clk);
      reset = 1'b1;
      step(4);
      chk_all("post_reset", 3'b000, 3'b000, 3'b000, 2'd3, 8'd0);

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(vecs[i].irq, vecs[i].blk, vecs[i].hexp, vecs[i].eret, vecs[i].ev);
         step(vecs[i].ncyc);
         chk_all($sformatf("vec%0d", i), vecs[i].p, vecs[i].s, vecs[i].x, vecs[i].id, vecs[i].lost);
      end

      // Lost-edge counter: 252 more edges to 254, then 48 more saturating at FF.
      for (int k = 0; k < 252; k++) begin
         @(negedge clk); drive(3'b000, 3'b000, 0, 0, 0); step(2);
         @(negedge clk); drive(3'b010, 3'b000, 0, 0, 0); step(2);
      end
      @(negedge clk); drive(3'b000, 3'b000, 0, 0, 0); step(3);
      chk("lost_254", bus.lost_cnt, 8'd254);
      for (int k = 0; k < 48; k++) begin
         @(negedge clk); drive(3'b000, 3'b000, 0, 0, 0); step(2);
         @(negedge clk); drive(3'b010, 3'b000, 0, 0, 0); step(2);
      end
      @(negedge clk); drive(3'b000, 3'b000, 0, 0, 0); step(3);
      chk("lost_sat", bus.lost_cnt, 8'hFF);
      chk("lost_sat.pending", 8'(bus.pending), 8'h02);

      // Ack and return source 1, then make 2 and 0 pending for the mask test.
      @(negedge clk); drive(3'b000, 3'b000, 1, 0, 0); step(1);
      chk("ack1.in_service", 8'(bus.in_service), 8'h02);
      @(negedge clk); drive(3'b000, 3'b000, 0, 1, 1); step(1);
      chk("eret1.in_service", 8'(bus.in_service), 8'h00);
      @(negedge clk); drive(3'b101, 3'b100, 0, 0, 0); step(3);
      @(negedge clk); drive(3'b000, 3'b100, 0, 0, 0); step(2);
      chk_all("mask2", 3'b101, 3'b000, 3'b001, 2'd0, 8'hFF);
      @(negedge clk);
      bus.block = 3'b000;
      #1;
      chk_all("unmask", 3'b101, 3'b000, 3'b100, 2'd2, 8'hFF);

      // Reset in the middle of service with all lines held high.
      @(negedge clk); drive(3'b000, 3'b000, 1, 0, 0); step(1);
      chk("ack2.in_service", 8'(bus.in_service), 8'h04);
      @(negedge clk); drive(3'b111, 3'b000, 0, 0, 0); step(4);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_all("mid_reset", 3'b000, 3'b000, 3'b000, 2'd3, 8'd0);
      step(2);
      @(negedge clk);
      reset = 1'b1;
      step(6);
      chk_all("held_high", 3'b000, 3'b000, 3'b000, 2'd3, 8'd0);
      @(negedge clk); drive(3'b000, 3'b000, 0, 0, 0); step(3);
      chk("fall.pending", 8'(bus.pending), 8'h00);
      @(negedge clk); drive(3'b001, 3'b000, 0, 0, 0); step(3);
      chk_all("re_rise", 3'b001, 3'b000, 3'b001, 2'd0, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
